cell_comm_rx_packet: RTL and testbench
======================================

CELL_COMM_RX_PACKET -- requirements
Module: cell_comm_rx_packet

Interface
REQ-001 The block SHALL have parameter FOFB_IDX_WIDTH, default 9, giving the width of the FOFB index field.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the AXIS word and counter width.
REQ-003 The block SHALL have parameter MAGIC, default 16'hA5BE, giving the required header tag.
REQ-004 The block SHALL have port auUserClk, input, 1 bit: the single Aurora user clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port auResetN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port channelUp, input, 1 bit: Aurora channel up.
REQ-007 The block SHALL have AXIS receive inputs axisRxTvalid (1), axisRxTlast (1) and axisRxTdata (DATA_WIDTH); there is no tready, so the sink cannot stall.
REQ-008 The block SHALL have inputs axisRxCRCvalid (1) and axisRxCRCpass (1): the CRC verdict, meaningful only on the tlast beat.
REQ-009 The block SHALL have port clearCounters, input, 1 bit: synchronous clear strobe for all counters.
REQ-010 The block SHALL have output outValid, 1 bit: one-cycle pulse marking an accepted packet.
REQ-011 The block SHALL have outputs outFofbIndex (FOFB_IDX_WIDTH) and outFofbEnable (1), taken from the header.
REQ-012 The block SHALL have outputs outX, outY and outS, each DATA_WIDTH bits, carrying the packet payload.
REQ-013 The block SHALL have outputs goodPackets, crcFaults, sizeFaults and headerFaults, each DATA_WIDTH bits.

Function
REQ-014 The packet format SHALL be 4 beats: header, X, Y, S; tlast is asserted on S only.
REQ-015 The header SHALL be laid out as: [31:16] MAGIC; [15] fofbEnable; [14:FOFB_IDX_WIDTH] zero; [FOFB_IDX_WIDTH-1:0] index.
REQ-016 The state machine SHALL have states HDR, WX, WY, WS and DRAIN; the reset state is HDR.
REQ-017 Beats SHALL be consumed only when axisRxTvalid=1; with axisRxTvalid=0 the state is held.
REQ-018 In HDR, a valid beat with matching magic and zero reserved bits SHALL latch the header fields and move to WX; any mismatch SHALL increment headerFaults and move to DRAIN.
REQ-019 In WX and WY, a beat SHALL latch X or Y respectively and advance to the next state.
REQ-020 In WS, a beat with tlast SHALL latch S and return to HDR.
REQ-021 In WS, a beat without tlast SHALL increment sizeFaults and move to DRAIN.
REQ-022 A tlast beat in HDR, WX or WY (short packet) SHALL increment sizeFaults and return to HDR.
REQ-023 DRAIN SHALL discard beats until a tlast beat, then return to HDR.
REQ-024 On any tlast beat where axisRxCRCvalid=1 and axisRxCRCpass=0, crcFaults SHALL increment instead of sizeFaults or headerFaults; at most one counter increments per packet.
REQ-025 On a complete 4-beat packet with good CRC, outValid SHALL pulse exactly 1 cycle after the S beat.
REQ-026 While outValid pulses, all out* fields SHALL be registered and stable, and goodPackets SHALL increment in the same cycle.
REQ-027 When axisRxCRCvalid=0 on the S beat, the packet SHALL be treated as good.
REQ-028 out* data registers SHALL update only on an accepted packet; they hold their values otherwise.
REQ-029 When channelUp=0, the state SHALL force to HDR, all beats SHALL be ignored, no counters SHALL change, and any partial packet SHALL be silently dropped.
REQ-030 All counters SHALL saturate at all-ones.
REQ-031 clearCounters SHALL zero all counters and SHALL take priority over a simultaneous increment.

Reset
REQ-032 While auResetN=0, the state SHALL be HDR and outValid, all out* fields and all counters SHALL be 0.
REQ-033 Reset assertion mid-packet SHALL take effect immediately (asynchronously), with no count recorded.
REQ-034 Reset release SHALL be synchronized externally; the first beat accepted after release is treated as a header.

Structure
REQ-035 The shared package SHALL hold the MAGIC default, the header field positions, the packet length (4) and the state encoding.
REQ-036 One sub-module, sat_counter (a DATA_WIDTH saturating counter with clear), SHALL be instantiated four times.

Verification
REQ-037 Verification SHALL cover this case: header 0xA5BE8005 then X=1, Y=2, S=3 with tlast and CRC pass -> outValid 1 cycle later, index=5, enable=1, X/Y/S=1/2/3, goodPackets=1.
REQ-038 Verification SHALL cover this case: the same packet with CRCvalid=1 and CRCpass=0 -> no outValid, crcFaults=1.
REQ-039 Verification SHALL cover this case: header 0x12348005 followed by 3 beats ending in tlast -> headerFaults=1 (DRAIN consumes the tail), after which the next good packet is accepted.
REQ-040 Verification SHALL cover this case: a 3-beat packet (tlast on Y) -> sizeFaults=1; a 5-beat packet -> sizeFaults=2, and DRAIN ends on its tlast.
REQ-041 Verification SHALL cover this case: channelUp dropped after X -> no counter change; after recovery a good packet yields outValid.
REQ-042 Verification SHALL cover this case: crcFaults forced to 0xFFFFFFFF plus a further CRC failure -> the counter stays at 0xFFFFFFFF; clearCounters coincident with goodPackets increment -> 0.

Source files
------------

// File: rtl/cell_comm_rx_packet_pkg.sv
// Shared constants for the Aurora cell-communication packet receiver:
// header field positions, packet length, FSM state encoding and the header check.
package cell_comm_rx_packet_pkg;

    localparam logic [15:0] MAGIC_DEFAULT  = 16'hA5BE;
    localparam int          HDR_MAGIC_MSB  = 31;
    localparam int          HDR_MAGIC_LSB  = 16;
    localparam int          HDR_ENABLE_BIT = 15;
    localparam int          HDR_RSVD_MSB   = 14;
    localparam int          PKT_BEATS      = 4;

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_WX    = 3'd1;
    localparam logic [2:0] ST_WY    = 3'd2;
    localparam logic [2:0] ST_WS    = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Header is good when the tag matches and every bit between the index and the enable flag is zero.
    function automatic logic hdr_valid(input logic [31:0] hdr, input logic [15:0] magic,
                                       input int idx_width);
        logic ok;
        ok = (hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == magic);
        for (int i = 0; i <= HDR_RSVD_MSB; i++) begin
            if ((i >= idx_width) && hdr[i]) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/cell_comm_rx_packet_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cell_comm_rx_packet.sv
// Receives 4-beat FOFB packets (header, X, Y, S) from an Aurora AXIS stream,
// publishes accepted packets as a one-cycle registered pulse and keeps fault statistics.
module cell_comm_rx_packet
    import cell_comm_rx_packet_pkg::*;
#(
    parameter int          FOFB_IDX_WIDTH = 9,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [15:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic                      auUserClk,
    input  logic                      auResetN,
    input  logic                      channelUp,
    input  logic                      axisRxTvalid,
    input  logic                      axisRxTlast,
    input  logic [DATA_WIDTH-1:0]     axisRxTdata,
    input  logic                      axisRxCRCvalid,
    input  logic                      axisRxCRCpass,
    input  logic                      clearCounters,
    output logic                      outValid,
    output logic [FOFB_IDX_WIDTH-1:0] outFofbIndex,
    output logic                      outFofbEnable,
    output logic [DATA_WIDTH-1:0]     outX,
    output logic [DATA_WIDTH-1:0]     outY,
    output logic [DATA_WIDTH-1:0]     outS,
    output logic [DATA_WIDTH-1:0]     goodPackets,
    output logic [DATA_WIDTH-1:0]     crcFaults,
    output logic [DATA_WIDTH-1:0]     sizeFaults,
    output logic [DATA_WIDTH-1:0]     headerFaults
);

    logic [2:0]                state_d, state_q;
    logic [FOFB_IDX_WIDTH-1:0] hdr_idx_d, hdr_idx_q;
    logic                      hdr_en_d, hdr_en_q;
    logic [DATA_WIDTH-1:0]     x_d, x_q, y_d, y_q;
    logic                      out_valid_d, out_valid_q;
    logic [FOFB_IDX_WIDTH-1:0] out_idx_d, out_idx_q;
    logic                      out_en_d, out_en_q;
    logic [DATA_WIDTH-1:0]     out_x_d, out_x_q, out_y_d, out_y_q, out_s_d, out_s_q;
    logic                      inc_good_s, inc_crc_s, inc_size_s, inc_hdr_s;
    logic                      crc_bad_s;
    logic                      hdr_ok_s;

    assign crc_bad_s = axisRxCRCvalid & ~axisRxCRCpass;
    assign hdr_ok_s  = hdr_valid(axisRxTdata[31:0], MAGIC, FOFB_IDX_WIDTH);

    // Packet FSM: one beat per valid cycle, faults classified at most once per packet.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        hdr_en_d    = hdr_en_q;
        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_en_d    = out_en_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_s_d     = out_s_q;
        inc_good_s  = 1'b0;
        inc_crc_s   = 1'b0;
        inc_size_s  = 1'b0;
        inc_hdr_s   = 1'b0;
        if (!channelUp) begin
            state_d = ST_HDR;
        end else if (axisRxTvalid) begin
            case (state_q)
                ST_HDR, ST_WX, ST_WY: begin
                    // A tlast here is a short packet, even a one-beat one with a bad header.
                    if (axisRxTlast) begin
                        inc_crc_s  = crc_bad_s;
                        inc_size_s = ~crc_bad_s;
                        state_d    = ST_HDR;
                    end else if (state_q == ST_HDR) begin
                        if (hdr_ok_s) begin
                            hdr_idx_d = axisRxTdata[FOFB_IDX_WIDTH-1:0];
                            hdr_en_d  = axisRxTdata[HDR_ENABLE_BIT];
                            state_d   = ST_WX;
                        end else begin
                            inc_hdr_s = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else if (state_q == ST_WX) begin
                        x_d     = axisRxTdata;
                        state_d = ST_WY;
                    end else begin
                        y_d     = axisRxTdata;
                        state_d = ST_WS;
                    end
                end
                ST_WS: begin
                    if (!axisRxTlast) begin
                        inc_size_s = 1'b1;
                        state_d    = ST_DRAIN;
                    end else if (crc_bad_s) begin
                        inc_crc_s = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        inc_good_s  = 1'b1;
                        out_valid_d = 1'b1;
                        out_idx_d   = hdr_idx_q;
                        out_en_d    = hdr_en_q;
                        out_x_d     = x_q;
                        out_y_d     = y_q;
                        out_s_d     = axisRxTdata;
                        state_d     = ST_HDR;
                    end
                end
                ST_DRAIN: begin
                    if (axisRxTlast) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, partial-packet and output registers.
    always_ff @(posedge auUserClk or negedge auResetN) begin
        if (!auResetN) begin
            state_q     <= ST_HDR;
            hdr_idx_q   <= '0;
            hdr_en_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_en_q    <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_s_q     <= '0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            hdr_en_q    <= hdr_en_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_en_q    <= out_en_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_s_q     <= out_s_d;
        end
    end

    assign outValid      = out_valid_q;
    assign outFofbIndex  = out_idx_q;
    assign outFofbEnable = out_en_q;
    assign outX          = out_x_q;
    assign outY          = out_y_q;
    assign outS          = out_s_q;

    sat_counter #(.WIDTH(DATA_WIDTH)) u_good_cnt (
        .clk(auUserClk), .rst_n(auResetN), .clr(clearCounters), .inc(inc_good_s), .count(goodPackets)
    );
    sat_counter #(.WIDTH(DATA_WIDTH)) u_crc_cnt (
        .clk(auUserClk), .rst_n(auResetN), .clr(clearCounters), .inc(inc_crc_s), .count(crcFaults)
    );
    sat_counter #(.WIDTH(DATA_WIDTH)) u_size_cnt (
        .clk(auUserClk), .rst_n(auResetN), .clr(clearCounters), .inc(inc_size_s), .count(sizeFaults)
    );
    sat_counter #(.WIDTH(DATA_WIDTH)) u_hdr_cnt (
        .clk(auUserClk), .rst_n(auResetN), .clr(clearCounters), .inc(inc_hdr_s), .count(headerFaults)
    );

endmodule

// File: tb/tb_cell_comm_rx_packet.sv
// Self-checking bench for cell_comm_rx_packet: directed scenarios plus random packets
// checked against a packet-level reference model.
module tb_cell_comm_rx_packet;
    import cell_comm_rx_packet_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, chan_up, tvalid, tlast, crcv, crcp, clr;
    logic [31:0] tdata;
    logic        out_valid, out_en;
    logic [8:0]  out_idx;
    logic [31:0] out_x, out_y, out_s, good_cnt, crc_cnt, size_cnt, hdr_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state.
    logic [31:0] exp_good, exp_crc, exp_size, exp_hdr, exp_x, exp_y, exp_s;
    logic [8:0]  exp_idx;
    logic        exp_en;

    // Packet to send.
    logic [31:0] pkt_w [0:7];
    int          pkt_len;
    logic        pkt_crcv, pkt_crcp, pkt_clr;
    bit          rand_idle = 1'b0;

    always #5 clk = ~clk;

    cell_comm_rx_packet dut (
        .auUserClk(clk), .auResetN(rst_n), .channelUp(chan_up),
        .axisRxTvalid(tvalid), .axisRxTlast(tlast), .axisRxTdata(tdata),
        .axisRxCRCvalid(crcv), .axisRxCRCpass(crcp), .clearCounters(clr),
        .outValid(out_valid), .outFofbIndex(out_idx), .outFofbEnable(out_en),
        .outX(out_x), .outY(out_y), .outS(out_s),
        .goodPackets(good_cnt), .crcFaults(crc_cnt), .sizeFaults(size_cnt), .headerFaults(hdr_cnt)
    );

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] make_hdr(input logic en, input logic [8:0] idx);
        return {16'hA5BE, en, 6'b000000, idx};
    endfunction

    task automatic model_reset();
        exp_good = 32'd0; exp_crc = 32'd0; exp_size = 32'd0; exp_hdr = 32'd0;
        exp_x = 32'd0; exp_y = 32'd0; exp_s = 32'd0; exp_idx = 9'd0; exp_en = 1'b0;
    endtask

    task automatic set_pkt4(input logic [31:0] h, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] s);
        pkt_w[0] = h; pkt_w[1] = x; pkt_w[2] = y; pkt_w[3] = s;
        pkt_len = PKT_BEATS; pkt_crcv = 1'b1; pkt_crcp = 1'b1; pkt_clr = 1'b0;
    endtask

    // Drive one packet, predict its outcome from packet-level rules, then check everything.
    task automatic run_packet(input string tag);
        logic [31:0] hdr;
        logic        hok, bad, exp_v;
        for (int i = 0; i < pkt_len; i++) begin
            if (rand_idle) begin
                repeat ($urandom_range(0, 2)) begin
                    tvalid = 1'b0; tdata = $urandom; tlast = 1'($urandom);
                    @(negedge clk);
                end
            end
            tvalid = 1'b1;
            tdata  = pkt_w[i];
            tlast  = (i == pkt_len - 1);
            crcv   = tlast ? pkt_crcv : 1'($urandom);
            crcp   = tlast ? pkt_crcp : 1'($urandom);
            clr    = tlast ? pkt_clr : 1'b0;
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0; clr = 1'b0;
        hdr = pkt_w[0];
        hok = (hdr[31:16] == 16'hA5BE) && (((hdr >> 9) & 32'h3F) == 32'd0);
        bad = pkt_crcv && !pkt_crcp;
        exp_v = 1'b0;
        if (pkt_len == 1) begin
            if (bad) exp_crc = sat_inc(exp_crc); else exp_size = sat_inc(exp_size);
        end else if (!hok) begin
            exp_hdr = sat_inc(exp_hdr);
        end else if (pkt_len < PKT_BEATS) begin
            if (bad) exp_crc = sat_inc(exp_crc); else exp_size = sat_inc(exp_size);
        end else if (pkt_len == PKT_BEATS) begin
            if (bad) begin
                exp_crc = sat_inc(exp_crc);
            end else begin
                exp_good = sat_inc(exp_good);
                exp_v = 1'b1;
                exp_idx = hdr[8:0]; exp_en = hdr[15];
                exp_x = pkt_w[1]; exp_y = pkt_w[2]; exp_s = pkt_w[3];
            end
        end else begin
            exp_size = sat_inc(exp_size);
        end
        if (pkt_clr) begin
            exp_good = 32'd0; exp_crc = 32'd0; exp_size = 32'd0; exp_hdr = 32'd0;
        end
        cmp_cnt++; if (out_valid !== exp_v) begin err_cnt++;
            $display("FAIL %s outValid: got %0b want %0b", tag, out_valid, exp_v); end
        cmp_cnt++; if (out_idx !== exp_idx || out_en !== exp_en) begin err_cnt++;
            $display("FAIL %s idx/en: got %0d/%0b want %0d/%0b", tag, out_idx, out_en, exp_idx, exp_en); end
        cmp_cnt++; if (out_x !== exp_x || out_y !== exp_y || out_s !== exp_s) begin err_cnt++;
            $display("FAIL %s xys: got %h/%h/%h want %h/%h/%h", tag, out_x, out_y, out_s, exp_x, exp_y, exp_s); end
        cmp_cnt++; if (good_cnt !== exp_good) begin err_cnt++;
            $display("FAIL %s goodPackets: got %h want %h", tag, good_cnt, exp_good); end
        cmp_cnt++; if (crc_cnt !== exp_crc) begin err_cnt++;
            $display("FAIL %s crcFaults: got %h want %h", tag, crc_cnt, exp_crc); end
        cmp_cnt++; if (size_cnt !== exp_size) begin err_cnt++;
            $display("FAIL %s sizeFaults: got %h want %h", tag, size_cnt, exp_size); end
        cmp_cnt++; if (hdr_cnt !== exp_hdr) begin err_cnt++;
            $display("FAIL %s headerFaults: got %h want %h", tag, hdr_cnt, exp_hdr); end
        @(negedge clk);
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++;
            $display("FAIL %s pulse width: outValid got %0b want 0", tag, out_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chan_up = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 32'd0;
        crcv = 1'b0; crcp = 1'b0; clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        cmp_cnt++; if (out_valid !== 1'b0 || out_idx !== 9'd0 || out_en !== 1'b0) begin err_cnt++;
            $display("FAIL reset flags: got v=%0b idx=%0d en=%0b want 0", out_valid, out_idx, out_en); end
        cmp_cnt++; if ({out_x, out_y, out_s} !== 96'd0) begin err_cnt++;
            $display("FAIL reset data: got %h/%h/%h want 0", out_x, out_y, out_s); end
        cmp_cnt++; if ({good_cnt, crc_cnt, size_cnt, hdr_cnt} !== 128'd0) begin err_cnt++;
            $display("FAIL reset counters: got %h/%h/%h/%h want 0", good_cnt, crc_cnt, size_cnt, hdr_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good();
        set_pkt4(32'hA5BE_8005, 32'd1, 32'd2, 32'd3);
        run_packet("good");
        cmp_cnt++; if (out_idx !== 9'd5 || out_en !== 1'b1 || good_cnt !== 32'd1) begin err_cnt++;
            $display("FAIL good fixed: got idx=%0d en=%0b good=%0d want 5/1/1", out_idx, out_en, good_cnt); end
    endtask

    task automatic test_crc_fail();
        set_pkt4(32'hA5BE_8005, 32'd11, 32'd12, 32'd13);
        pkt_crcp = 1'b0;
        run_packet("crc_fail");
        cmp_cnt++; if (crc_cnt !== 32'd1) begin err_cnt++;
            $display("FAIL crc_fail fixed: got %0d want 1", crc_cnt); end
        set_pkt4(32'hA5BE_0007, 32'd21, 32'd22, 32'd23);
        pkt_crcv = 1'b0; pkt_crcp = 1'b0;
        run_packet("crc_not_valid");
    endtask

    task automatic test_header_fault();
        set_pkt4(32'h1234_8005, 32'd4, 32'd5, 32'd6);
        run_packet("hdr_magic");
        cmp_cnt++; if (hdr_cnt !== 32'd1) begin err_cnt++;
            $display("FAIL hdr_magic fixed: got %0d want 1", hdr_cnt); end
        set_pkt4(32'hA5BE_0200, 32'd4, 32'd5, 32'd6);
        run_packet("hdr_reserved");
        set_pkt4(make_hdr(1'b1, 9'd511), 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF);
        run_packet("after_hdr_fault");
    endtask

    task automatic test_size();
        set_pkt4(make_hdr(1'b0, 9'd3), 32'd7, 32'd8, 32'd0);
        pkt_len = 3;
        run_packet("short3");
        cmp_cnt++; if (size_cnt !== 32'd1) begin err_cnt++;
            $display("FAIL short3 fixed: got %0d want 1", size_cnt); end
        set_pkt4(make_hdr(1'b0, 9'd3), 32'd7, 32'd8, 32'd9);
        pkt_w[4] = 32'd10; pkt_len = 5;
        run_packet("long5");
        cmp_cnt++; if (size_cnt !== 32'd2) begin err_cnt++;
            $display("FAIL long5 fixed: got %0d want 2", size_cnt); end
        set_pkt4(make_hdr(1'b1, 9'd42), 32'd100, 32'd200, 32'd300);
        run_packet("after_drain");
    endtask

    task automatic test_channel_down();
        logic [127:0] snap;
        snap = {exp_good, exp_crc, exp_size, exp_hdr};
        tvalid = 1'b1; tlast = 1'b0; tdata = make_hdr(1'b1, 9'd9); @(negedge clk);
        tdata = 32'd55; @(negedge clk);
        chan_up = 1'b0;
        tdata = 32'd66; @(negedge clk);
        tdata = 32'd77; tlast = 1'b1; crcv = 1'b1; crcp = 1'b0; @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        cmp_cnt++; if ({good_cnt, crc_cnt, size_cnt, hdr_cnt} !== snap || out_valid !== 1'b0) begin err_cnt++;
            $display("FAIL chan_down counters: got %h/%h/%h/%h v=%0b want unchanged, v=0",
                     good_cnt, crc_cnt, size_cnt, hdr_cnt, out_valid); end
        chan_up = 1'b1;
        @(negedge clk);
        set_pkt4(make_hdr(1'b0, 9'd17), 32'd1000, 32'd2000, 32'd3000);
        run_packet("chan_recover");
    endtask

    task automatic test_saturate_clear();
        force dut.u_crc_cnt.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_crc_cnt.count_q;
        exp_crc = 32'hFFFF_FFFF;
        set_pkt4(make_hdr(1'b1, 9'd1), 32'd1, 32'd1, 32'd1);
        pkt_crcp = 1'b0;
        run_packet("crc_saturate");
        cmp_cnt++; if (crc_cnt !== 32'hFFFF_FFFF) begin err_cnt++;
            $display("FAIL crc_saturate fixed: got %h want ffffffff", crc_cnt); end
        set_pkt4(make_hdr(1'b1, 9'd2), 32'd5, 32'd6, 32'd7);
        pkt_clr = 1'b1;
        run_packet("clear_priority");
        cmp_cnt++; if (good_cnt !== 32'd0) begin err_cnt++;
            $display("FAIL clear_priority fixed: got %0d want 0", good_cnt); end
    endtask

    task automatic test_random();
        int r;
        rand_idle = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      pkt_w[0] = make_hdr(1'($urandom), 9'($urandom));
            else if (r < 9) pkt_w[0] = {16'($urandom), 16'h0001};
            else            pkt_w[0] = make_hdr(1'b0, 9'd1) | (32'd1 << $urandom_range(9, 14));
            for (int i = 1; i < 8; i++) pkt_w[i] = $urandom;
            r = $urandom_range(0, 9);
            pkt_len  = (r < 6) ? PKT_BEATS : $urandom_range(1, 6);
            pkt_crcv = 1'($urandom);
            pkt_crcp = ($urandom_range(0, 4) != 0);
            pkt_clr  = ($urandom_range(0, 19) == 0);
            run_packet("random");
        end
        rand_idle = 1'b0;
    endtask

    task automatic test_async_reset();
        tvalid = 1'b1; tlast = 1'b0; tdata = make_hdr(1'b1, 9'd8); @(negedge clk);
        tdata = 32'd123; @(negedge clk);
        tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++; if ({good_cnt, crc_cnt, size_cnt, hdr_cnt} !== 128'd0 || out_x !== 32'd0) begin err_cnt++;
            $display("FAIL async_reset: got %h/%h/%h/%h x=%h want 0", good_cnt, crc_cnt, size_cnt, hdr_cnt, out_x); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_pkt4(make_hdr(1'b1, 9'd300), 32'd31, 32'd32, 32'd33);
        run_packet("after_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_fail();
        test_header_fault();
        test_size();
        test_channel_down();
        test_saturate_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
